// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for the 5-stage pipeline.
// Owns the PC and drives the imem address. It tracks the single in-flight
// synchronous imem read and fills the F/D latch. A one-entry skid register
// keeps the instruction that returns while decode is stalled.
// Optional build macro: FETCH_PERF_CNT_EN adds the stall_cycles and
// bubble_cycles counters.
module fetch_stage #(
   parameter int          ADDR_WIDTH = 12,
   parameter logic [31:0] RESET_PC   = 32'd0
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] address_imem,
   input  logic [31:0]           q_imem,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [31:0]           redirect_pc,
   output logic                  fd_valid,
   output logic [31:0]           fd_insn,
   output logic [31:0]           fd_pc,
   output logic [31:0]           fd_pc_plus1,
   output logic [31:0]           pc_out
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]           stall_cycles,
   output logic [31:0]           bubble_cycles
`endif
);

   // EMPTY: the in-flight slot holds no real read. RUN: streaming.
   // HOLD: decode is stalled and the skid register holds the returned word.
   typedef enum logic [1:0] {EMPTY, RUN, HOLD} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc, pc_nxt;
   logic [31:0] infl_pc, infl_pc_nxt;
   logic        infl_valid, infl_valid_nxt;
   logic [31:0] skid_insn, skid_insn_nxt;
   logic [31:0] skid_pc, skid_pc_nxt;
   logic        skid_valid, skid_valid_nxt;
   logic        fd_valid_q, fd_valid_nxt;
   logic [31:0] fd_insn_q, fd_insn_nxt;
   logic [31:0] fd_pc_q, fd_pc_nxt;
   logic [31:0] ret_insn;

   // The returning word is a nop unless the read that produced it was real.
   assign ret_insn = infl_valid ? q_imem : 32'd0;

   // Next-state and next-register values: redirect > stall > normal.
   always_comb begin
      // NOTE: every signal gets a hold default first, so no path can infer a latch.
      state_nxt      = state;
      pc_nxt         = pc;
      infl_pc_nxt    = infl_pc;
      infl_valid_nxt = infl_valid;
      skid_insn_nxt  = skid_insn;
      skid_pc_nxt    = skid_pc;
      skid_valid_nxt = skid_valid;
      fd_valid_nxt   = fd_valid_q;
      fd_insn_nxt    = fd_insn_q;
      fd_pc_nxt      = fd_pc_q;

      if (redirect) begin
         // Squash everything on the wrong path, including a held skid entry.
         fd_valid_nxt   = 1'b0;
         fd_insn_nxt    = 32'd0;
         infl_valid_nxt = 1'b0;
         skid_valid_nxt = 1'b0;
         pc_nxt         = redirect_pc;
         state_nxt      = EMPTY;
      end else if (state == HOLD) begin
         if (!stall) begin
            // Drain the skid into F/D and re-issue the read of pc, which
            // imem has been presenting throughout the hold.
            fd_valid_nxt   = skid_valid;
            fd_insn_nxt    = skid_insn;
            fd_pc_nxt      = skid_pc;
            infl_pc_nxt    = pc;
            infl_valid_nxt = 1'b1;
            pc_nxt         = pc + 32'd1;
            skid_valid_nxt = 1'b0;
            state_nxt      = RUN;
         end
      end else if (stall) begin
         // F/D is frozen, so park the returning word in the skid.
         skid_valid_nxt = infl_valid;
         skid_insn_nxt  = ret_insn;
         skid_pc_nxt    = infl_pc;
         infl_pc_nxt    = pc;
         infl_valid_nxt = 1'b1;
         state_nxt      = HOLD;
      end else begin
         fd_valid_nxt   = infl_valid;
         fd_insn_nxt    = ret_insn;
         fd_pc_nxt      = infl_pc;
         infl_pc_nxt    = pc;
         infl_valid_nxt = 1'b1;
         pc_nxt         = pc + 32'd1;
         state_nxt      = RUN;
      end
   end

   // Register update; synchronous active-low reset overrides all controls.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so that every
      // register samples the pre-edge values.
      if (!reset) begin
         state      <= EMPTY;
         pc         <= RESET_PC;
         infl_pc    <= RESET_PC;
         infl_valid <= 1'b0;
         skid_insn  <= 32'd0;
         skid_pc    <= 32'd0;
         skid_valid <= 1'b0;
         fd_valid_q <= 1'b0;
         fd_insn_q  <= 32'd0;
         fd_pc_q    <= 32'd0;
      end else begin
         state      <= state_nxt;
         pc         <= pc_nxt;
         infl_pc    <= infl_pc_nxt;
         infl_valid <= infl_valid_nxt;
         skid_insn  <= skid_insn_nxt;
         skid_pc    <= skid_pc_nxt;
         skid_valid <= skid_valid_nxt;
         fd_valid_q <= fd_valid_nxt;
         fd_insn_q  <= fd_insn_nxt;
         fd_pc_q    <= fd_pc_nxt;
      end
   end

   assign address_imem = pc[ADDR_WIDTH-1:0];
   assign pc_out       = pc;
   assign fd_valid     = fd_valid_q;
   assign fd_insn      = fd_insn_q;
   assign fd_pc        = fd_pc_q;
   assign fd_pc_plus1  = fd_pc_q + 32'd1;

`ifdef FETCH_PERF_CNT_EN
   // Saturating event counters for stalled edges and bubble-loading edges.
   always_ff @(posedge clock) begin
      if (!reset) begin
         stall_cycles  <= 32'd0;
         bubble_cycles <= 32'd0;
      end else begin
         if (stall && !redirect && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
         if (!fd_valid_nxt && (bubble_cycles != 32'hFFFF_FFFF))
            bubble_cycles <= bubble_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. It covers reset release,
// stall/skid, redirect (alone, with stall, and inside HOLD), reset during
// HOLD, PC wrap at 2^32, and imem address wrap with RESET_PC=4094.
module tb_fetch_stage;

   logic        clock = 1'b0;
   logic        reset, stall, redirect;
   logic [31:0] redirect_pc;
   logic [11:0] address_imem;
   logic [31:0] q_imem;
   logic        fd_valid;
   logic [31:0] fd_insn, fd_pc, fd_pc_plus1, pc_out;

   logic        reset_w;
   logic [11:0] address_imem_w;
   logic [31:0] q_imem_w;
   logic        fd_valid_w;
   logic [31:0] fd_insn_w, fd_pc_w, fd_pc_plus1_w, pc_out_w;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cycles, bubble_cycles, stall_cycles_w, bubble_cycles_w;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   // Synchronous imem models: mem[i] = A0000000 + i.
   always @(posedge clock) q_imem   <= 32'hA000_0000 + {20'd0, address_imem};
   always @(posedge clock) q_imem_w <= 32'hA000_0000 + {20'd0, address_imem_w};

   fetch_stage #(.ADDR_WIDTH(12), .RESET_PC(32'd0)) u_dut (
      .clock(clock), .reset(reset), .address_imem(address_imem), .q_imem(q_imem),
      .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .fd_valid(fd_valid), .fd_insn(fd_insn), .fd_pc(fd_pc),
      .fd_pc_plus1(fd_pc_plus1), .pc_out(pc_out)
`ifdef FETCH_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .bubble_cycles(bubble_cycles)
`endif
   );

   fetch_stage #(.ADDR_WIDTH(12), .RESET_PC(32'd4094)) u_wrap (
      .clock(clock), .reset(reset_w), .address_imem(address_imem_w), .q_imem(q_imem_w),
      .stall(1'b0), .redirect(1'b0), .redirect_pc(32'd0),
      .fd_valid(fd_valid_w), .fd_insn(fd_insn_w), .fd_pc(fd_pc_w),
      .fd_pc_plus1(fd_pc_plus1_w), .pc_out(pc_out_w)
`ifdef FETCH_PERF_CNT_EN
      , .stall_cycles(stall_cycles_w), .bubble_cycles(bubble_cycles_w)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit later.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_fd(input string tag, input logic v, input logic [31:0] insn,
                            input logic [31:0] pc);
      check({tag, ".valid"}, {31'd0, fd_valid}, {31'd0, v});
      check({tag, ".insn"}, fd_insn, insn);
      if (v) begin
         check({tag, ".pc"}, fd_pc, pc);
         check({tag, ".pc_plus1"}, fd_pc_plus1, pc + 32'd1);
      end
   endtask

   // Reset for 2 edges, release, then advance n edges (fd_pc = n-2).
   task automatic restart(input int n);
      reset = 1'b0; stall = 1'b0; redirect = 1'b0;
      step(); step();
      reset = 1'b1;
      repeat (n) step();
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
      reset_w = 1'b0;
      #2;

      // Reset release and fill latency
      step(); step();
      check("rst.valid", {31'd0, fd_valid}, 32'd0);
      check("rst.insn", fd_insn, 32'd0);
      check("rst.pc", fd_pc, 32'd0);
      check("rst.pc_plus1", fd_pc_plus1, 32'd1);
      check("rst.pc_out", pc_out, 32'd0);
      check("rst.addr", {20'd0, address_imem}, 32'd0);
      reset = 1'b1;
      step(); expect_fd("e1", 1'b0, 32'd0, 32'd0);
      step(); expect_fd("e2", 1'b1, 32'hA000_0000, 32'd0);
      step(); step(); step();
      expect_fd("e5", 1'b1, 32'hA000_0003, 32'd3);

      // Stall for 3 edges: F/D and PC hold, then 4,5,6 without gap
      stall = 1'b1;
      step(); expect_fd("stall1", 1'b1, 32'hA000_0003, 32'd3);
      step(); expect_fd("stall2", 1'b1, 32'hA000_0003, 32'd3);
      step(); expect_fd("stall3", 1'b1, 32'hA000_0003, 32'd3);
      check("stall.pc_out", pc_out, 32'd5);
      stall = 1'b0;
      step(); expect_fd("rel4", 1'b1, 32'hA000_0004, 32'd4);
      step(); expect_fd("rel5", 1'b1, 32'hA000_0005, 32'd5);
      step(); expect_fd("rel6", 1'b1, 32'hA000_0006, 32'd6);

      // Redirect to 100 at the edge after fd_pc=5
      restart(7);
      expect_fd("rd.pre", 1'b1, 32'hA000_0005, 32'd5);
      redirect = 1'b1; redirect_pc = 32'd100;
      step(); redirect = 1'b0;
      expect_fd("rd.b1", 1'b0, 32'd0, 32'd0);
      check("rd.pc_out", pc_out, 32'd100);
      check("rd.addr", {20'd0, address_imem}, 32'd100);
      step(); expect_fd("rd.b2", 1'b0, 32'd0, 32'd0);
      step(); expect_fd("rd.t0", 1'b1, 32'hA000_0064, 32'd100);
      step(); expect_fd("rd.t1", 1'b1, 32'hA000_0065, 32'd101);

      // Redirect together with stall: same outcome as redirect alone
      restart(7);
      redirect = 1'b1; stall = 1'b1; redirect_pc = 32'd100;
      step(); redirect = 1'b0; stall = 1'b0;
      expect_fd("rs.b1", 1'b0, 32'd0, 32'd0);
      step(); expect_fd("rs.b2", 1'b0, 32'd0, 32'd0);
      step(); expect_fd("rs.t0", 1'b1, 32'hA000_0064, 32'd100);
      step(); expect_fd("rs.t1", 1'b1, 32'hA000_0065, 32'd101);

      // Redirect while in HOLD discards the skid entry (insn 6)
      restart(7);
      stall = 1'b1;
      step(); expect_fd("rh.hold", 1'b1, 32'hA000_0005, 32'd5);
      redirect = 1'b1; redirect_pc = 32'd100;
      step(); redirect = 1'b0; stall = 1'b0;
      expect_fd("rh.b1", 1'b0, 32'd0, 32'd0);
      step(); expect_fd("rh.b2", 1'b0, 32'd0, 32'd0);
      step(); expect_fd("rh.t0", 1'b1, 32'hA000_0064, 32'd100);

      // Reset during HOLD
      restart(7);
      stall = 1'b1;
      step(); step();
      reset = 1'b0;
      step();
      check("rmh.valid", {31'd0, fd_valid}, 32'd0);
      check("rmh.insn", fd_insn, 32'd0);
      check("rmh.pc", fd_pc, 32'd0);
      check("rmh.pc_plus1", fd_pc_plus1, 32'd1);
      check("rmh.pc_out", pc_out, 32'd0);
      reset = 1'b1; stall = 1'b0;
      step(); expect_fd("rmh.e1", 1'b0, 32'd0, 32'd0);
      step(); expect_fd("rmh.e2", 1'b1, 32'hA000_0000, 32'd0);
      step(); expect_fd("rmh.e3", 1'b1, 32'hA000_0001, 32'd1);

      // PC wraps modulo 2^32
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
      step(); redirect = 1'b0;
      step();
      check("pw.pc_out", pc_out, 32'd0);
      step(); expect_fd("pw.top", 1'b1, 32'hA000_0FFF, 32'hFFFF_FFFF);
      step(); expect_fd("pw.zero", 1'b1, 32'hA000_0000, 32'd0);

      // imem address wrap with RESET_PC=4094
      reset_w = 1'b1;
      step();
      check("wr.e1.valid", {31'd0, fd_valid_w}, 32'd0);
      check("wr.e1.insn", fd_insn_w, 32'd0);
      step();
      check("wr.e2.pc", fd_pc_w, 32'd4094);
      check("wr.e2.insn", fd_insn_w, 32'hA000_0FFE);
      check("wr.e2.pc_out", pc_out_w, 32'd4096);
      check("wr.e2.addr", {20'd0, address_imem_w}, 32'd0);
      step();
      check("wr.e3.pc", fd_pc_w, 32'd4095);
      check("wr.e3.insn", fd_insn_w, 32'hA000_0FFF);
      step();
      check("wr.e4.valid", {31'd0, fd_valid_w}, 32'd1);
      check("wr.e4.pc", fd_pc_w, 32'd4096);
      check("wr.e4.insn", fd_insn_w, 32'hA000_0000);
      check("wr.e4.pc_plus1", fd_pc_plus1_w, 32'd4097);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
